pe_brick_sequencer: RTL and testbench

- Feeds the 16-brick (2b x 2b) processing element: accepts packed activation/weight words and drives the PE operand inputs (activation, weight, signedness flags, shift code) one pass per cycle.
- Collects the PE's registered product and accumulates it into a weighted dot-product result, returned over a valid/ready handshake.
- Supports a 2-bit mode (16 lanes, 1 pass) and a 4-bit mode (8 lanes, 4 passes).
- Sits between the operand buffer and one PE instance.

---
 rtl/pe_brick_sequencer_if.sv | 44 ++++
 rtl/pe_brick_sequencer.sv | 176 +++++++++++++++++
 tb/tb_pe_brick_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pe_brick_sequencer_if.sv
// pe_brick_sequencer_if: operand, PE and result bus for pe_brick_sequencer.
// Signals:
//   i_valid/o_ready              operand handshake from the operand buffer
//   i_activation/i_weight        packed 32-bit operand words
//   i_mode, i_A_signed, i_W_signed  lane mode (0 = 16x2b, 1 = 8x4b) and signedness
//   o_pe_*                       operand drive to the 16-brick PE
//   i_pe_prod                    registered PE product (signed, PROD_W bits)
//   o_valid/i_ready/o_result     result handshake (signed, ACC_W bits)
// Modports: slave = sequencer side, master = buffer/PE/consumer side.
interface pe_brick_sequencer_if #(
   parameter int unsigned PROD_W = 15,
   parameter int unsigned ACC_W  = 16
);
   logic                     i_valid;
   logic                     o_ready;
   logic [31:0]              i_activation;
   logic [31:0]              i_weight;
   logic                     i_mode;
   logic                     i_A_signed;
   logic                     i_W_signed;
   logic [31:0]              o_pe_activation;
   logic [31:0]              o_pe_weight;
   logic                     o_pe_A_signed;
   logic                     o_pe_W_signed;
   logic [3:0]               o_pe_shift_amount;
   logic signed [PROD_W-1:0] i_pe_prod;
   logic                     o_valid;
   logic                     i_ready;
   logic signed [ACC_W-1:0]  o_result;

   modport slave (
      input  i_valid, i_activation, i_weight, i_mode, i_A_signed, i_W_signed,
      input  i_pe_prod, i_ready,
      output o_ready, o_pe_activation, o_pe_weight, o_pe_A_signed, o_pe_W_signed,
      output o_pe_shift_amount, o_valid, o_result
   );

   modport master (
      output i_valid, i_activation, i_weight, i_mode, i_A_signed, i_W_signed,
      output i_pe_prod, i_ready,
      input  o_ready, o_pe_activation, o_pe_weight, o_pe_A_signed, o_pe_W_signed,
      input  o_pe_shift_amount, o_valid, o_result
   );
endinterface

// File: rtl/pe_brick_sequencer.sv
// pe_brick_sequencer: sequences packed operand words through a 16-brick
// (2b x 2b) PE and accumulates the weighted partial products into a signed
// dot-product result.
// Ports:
//   i_clk   clock
//   i_rst   asynchronous reset, active-high
//   bus     pe_brick_sequencer_if.slave (operand, PE and result signals)
// Timing (accept edge = cycle 0): 2b result valid in cycle 3, 4b in cycle 6.
module pe_brick_sequencer #(
   parameter int unsigned PROD_W = 15,
   parameter int unsigned ACC_W  = 16
) (
   input logic                  i_clk,
   input logic                  i_rst,
   pe_brick_sequencer_if.slave  bus
);
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned LANES4  = 8;
   localparam int unsigned SHIFT_W = 3;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

   state_t                   state_q, state_d;
   logic [WORD_W-1:0]        act_q, wt_q;
   logic                     mode_q, as_q, ws_q;
   logic [1:0]               pass_q;
   logic                     pv_q;
   logic [SHIFT_W-1:0]       wsh_q;
   logic signed [ACC_W-1:0]  acc_q;

   logic                     issue_c;
   logic [1:0]               issue_pass_c;
   logic [WORD_W-1:0]        src_act_c, src_wt_c;
   logic                     src_mode_c, src_as_c, src_ws_c;
   logic [WORD_W-1:0]        pe_act_c, pe_wt_c;
   logic                     pe_as_c, pe_ws_c;
   logic                     last_c;
   logic signed [PROD_W-1:0] prod_c;
   logic signed [ACC_W-1:0]  prod_ext_c;

   // Pass weight as a left shift: 1, 4, 4, 16 in 4b mode; 1 in 2b mode.
   function automatic logic [SHIFT_W-1:0] pass_shift(input logic mode, input logic [1:0] p);
      logic [SHIFT_W-1:0] sh;
      sh = 3'd0;
      if (mode) begin
         case (p)
            2'd0:    sh = 3'd0;
            2'd3:    sh = 3'd4;
            default: sh = 3'd2;
         endcase
      end
      return sh;
   endfunction

   assign last_c     = !mode_q || (pass_q == 2'd3);
   assign prod_c     = bus.i_pe_prod;
   assign prod_ext_c = ACC_W'(prod_c);

   // Next state and selection of the pass to issue on this edge.
   // Pass 0 is issued on the accept edge straight from the input words.
   always_comb begin
      state_d      = state_q;
      issue_c      = 1'b0;
      issue_pass_c = pass_q;
      src_act_c    = act_q;
      src_wt_c     = wt_q;
      src_mode_c   = mode_q;
      src_as_c     = as_q;
      src_ws_c     = ws_q;
      case (state_q)
         IDLE: begin
            if (bus.i_valid) begin
               state_d      = RUN;
               issue_c      = 1'b1;
               issue_pass_c = 2'd0;
               src_act_c    = bus.i_activation;
               src_wt_c     = bus.i_weight;
               src_mode_c   = bus.i_mode;
               src_as_c     = bus.i_A_signed;
               src_ws_c     = bus.i_W_signed;
            end
         end
         RUN: begin
            if (last_c) begin
               state_d = DRAIN;
            end else begin
               issue_c      = 1'b1;
               issue_pass_c = pass_q + 2'd1;
            end
         end
         DRAIN: state_d = OUT;
         OUT: begin
            if (bus.o_valid && bus.i_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // PE operand words for the selected pass; 4b mode splits each nibble lane
   // into lo/hi 2-bit halves and only the lo-half sign flags are cleared.
   always_comb begin
      pe_act_c = src_act_c;
      pe_wt_c  = src_wt_c;
      pe_as_c  = src_as_c;
      pe_ws_c  = src_ws_c;
      if (src_mode_c) begin
         pe_act_c = '0;
         pe_wt_c  = '0;
         for (int j = 0; j < LANES4; j++) begin
            pe_act_c[2*j +: 2] = src_act_c[4*j + (issue_pass_c[1] ? 2 : 0) +: 2];
            pe_wt_c[2*j +: 2]  = src_wt_c[4*j + (issue_pass_c[0] ? 2 : 0) +: 2];
         end
         pe_as_c = src_as_c & issue_pass_c[1];
         pe_ws_c = src_ws_c & issue_pass_c[0];
      end
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Operand latch, pass counter and accumulation pipeline.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         act_q  <= '0;
         wt_q   <= '0;
         mode_q <= 1'b0;
         as_q   <= 1'b0;
         ws_q   <= 1'b0;
         pass_q <= 2'd0;
         pv_q   <= 1'b0;
         wsh_q  <= '0;
         acc_q  <= '0;
      end else begin
         if (state_q == IDLE && bus.i_valid) begin
            act_q  <= bus.i_activation;
            wt_q   <= bus.i_weight;
            mode_q <= bus.i_mode;
            as_q   <= bus.i_A_signed;
            ws_q   <= bus.i_W_signed;
         end
         if (issue_c) pass_q <= issue_pass_c;
         // The PE product of a RUN cycle's operands shows up one cycle later.
         pv_q  <= (state_q == RUN);
         wsh_q <= pass_shift(mode_q, pass_q);
         if (state_q == IDLE && bus.i_valid) acc_q <= '0;
         else if (pv_q)                      acc_q <= acc_q + (prod_ext_c <<< wsh_q);
      end
   end

   // Registered PE drive and result handshake.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         bus.o_ready           <= 1'b1;
         bus.o_pe_activation   <= '0;
         bus.o_pe_weight       <= '0;
         bus.o_pe_A_signed     <= 1'b0;
         bus.o_pe_W_signed     <= 1'b0;
         bus.o_pe_shift_amount <= 4'd0;
         bus.o_valid           <= 1'b0;
         bus.o_result          <= '0;
      end else begin
         bus.o_ready           <= (state_d == IDLE);
         bus.o_pe_activation   <= issue_c ? pe_act_c : '0;
         bus.o_pe_weight       <= issue_c ? pe_wt_c : '0;
         bus.o_pe_A_signed     <= issue_c & pe_as_c;
         bus.o_pe_W_signed     <= issue_c & pe_ws_c;
         bus.o_pe_shift_amount <= 4'd0;
         // First OUT cycle loads the result; it then holds until taken.
         bus.o_valid <= (state_q == OUT) && !(bus.o_valid && bus.i_ready);
         if (state_q == OUT && !bus.o_valid) bus.o_result <= acc_q;
      end
   end
endmodule

// File: tb/tb_pe_brick_sequencer.sv
// tb_pe_brick_sequencer: directed test of pe_brick_sequencer with a behavioural
// 16-brick PE model and an expected-result queue.
module tb_pe_brick_sequencer;
   localparam int unsigned PROD_W = 15;
   localparam int unsigned ACC_W  = 16;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [ACC_W-1:0] exp_q[$];

   always #5 clk = ~clk;

   pe_brick_sequencer_if #(.PROD_W(PROD_W), .ACC_W(ACC_W)) bus ();

   pe_brick_sequencer #(.PROD_W(PROD_W), .ACC_W(ACC_W)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // 16 bricks of 2b x 2b, summed, shifted by the shift code, registered.
   function automatic logic signed [PROD_W-1:0] pe_model(
      input logic [31:0] a, input logic [31:0] w,
      input logic as_, input logic ws_, input logic [3:0] sh);
      int sum;
      int av;
      int wv;
      logic [1:0] ab;
      logic [1:0] wb;
      sum = 0;
      for (int i = 0; i < 16; i++) begin
         ab = a[2*i +: 2];
         wb = w[2*i +: 2];
         av = as_ ? int'($signed(ab)) : int'(ab);
         wv = ws_ ? int'($signed(wb)) : int'(wb);
         sum = sum + av * wv;
      end
      sum = sum <<< sh;
      return PROD_W'(sum);
   endfunction

   always @(posedge clk)
      bus.i_pe_prod <= pe_model(bus.o_pe_activation, bus.o_pe_weight,
                                bus.o_pe_A_signed, bus.o_pe_W_signed, bus.o_pe_shift_amount);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present an operand pair in an IDLE cycle and return just after the accept edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] w, input logic m,
                        input logic as_, input logic ws_, input logic [ACC_W-1:0] exp,
                        input bit push, input bit hold);
      @(negedge clk);
      check("ready_before_accept", 32'(bus.o_ready), 32'd1);
      bus.i_activation = a;
      bus.i_weight     = w;
      bus.i_mode       = m;
      bus.i_A_signed   = as_;
      bus.i_W_signed   = ws_;
      bus.i_valid      = 1'b1;
      if (push) exp_q.push_back(exp);
      @(posedge clk);
      #1;
      if (!hold) bus.i_valid = 1'b0;
   endtask

   // Follow one operation from cycle 0 to the result handshake.
   task automatic collect(input int lat_exp, input int stall, input logic m,
                          input logic as_, input logic ws_);
      int   passes;
      int   cyc;
      bit   seen;
      logic [1:0] p;
      logic [ACC_W-1:0] held;
      logic [ACC_W-1:0] exp;
      passes = m ? 4 : 1;
      seen = 0;
      cyc  = -1;
      bus.i_ready = (stall == 0);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (c == 0) check("ready_low_busy", 32'(bus.o_ready), 32'd0);
         if (c < passes) begin
            p = 2'(c);
            check("pe_A_flag", 32'(bus.o_pe_A_signed), 32'(m ? (as_ & p[1]) : as_));
            check("pe_W_flag", 32'(bus.o_pe_W_signed), 32'(m ? (ws_ & p[0]) : ws_));
            check("pe_shift", 32'(bus.o_pe_shift_amount), 32'd0);
            if (m) check("pe_upper_zero",
                         32'(bus.o_pe_activation[31:16] | bus.o_pe_weight[31:16]), 32'd0);
         end
         if (c == passes) check("pe_zero_after_run", bus.o_pe_activation | bus.o_pe_weight, 32'd0);
         if (bus.o_valid) begin
            seen = 1;
            cyc  = c;
            break;
         end
      end
      check("valid_seen", 32'(seen), 32'd1);
      check("latency", 32'(cyc), 32'(lat_exp));
      held = bus.o_result;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check("stall_valid", 32'(bus.o_valid), 32'd1);
         check("stall_result", 32'(bus.o_result), 32'(held));
         check("stall_ready", 32'(bus.o_ready), 32'd0);
      end
      bus.i_ready = 1'b1;
      check("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      check("result", 32'($unsigned(bus.o_result)), 32'(exp));
      @(posedge clk);
      @(negedge clk);
      check("valid_dropped", 32'(bus.o_valid), 32'd0);
      check("ready_in_idle", 32'(bus.o_ready), 32'd1);
   endtask

   initial begin
      rst = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_activation = '0;
      bus.i_weight = '0;
      bus.i_mode = 1'b0;
      bus.i_A_signed = 1'b0;
      bus.i_W_signed = 1'b0;
      bus.i_ready = 1'b1;
      #1 rst = 1'b1;
      #1;
      check("rst_ready", 32'(bus.o_ready), 32'd1);
      check("rst_valid", 32'(bus.o_valid), 32'd0);
      check("rst_result", 32'($unsigned(bus.o_result)), 32'd0);
      check("rst_pe_act", bus.o_pe_activation, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // 2b unsigned: 16 * 3 * 3
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 16'd144, 1, 0);
      collect(3, 0, 1'b0, 1'b0, 1'b0);
      // 2b signed: 16 * (-2) * 1
      issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b1, 1'b1, 16'hFFE0, 1, 0);
      collect(3, 0, 1'b0, 1'b1, 1'b1);
      // 4b signed: 8 * (-8) * (-8)
      issue(32'h8888_8888, 32'h8888_8888, 1'b1, 1'b1, 1'b1, 16'd512, 1, 0);
      collect(6, 0, 1'b1, 1'b1, 1'b1);
      // 4b unsigned: 8 * 15 * 15
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 16'd1800, 1, 0);
      collect(6, 0, 1'b1, 1'b0, 1'b0);
      // 4b mixed: 3 * 15
      issue(32'h0000_0003, 32'h0000_000F, 1'b1, 1'b1, 1'b0, 16'd45, 1, 0);
      collect(6, 0, 1'b1, 1'b1, 1'b0);

      // Backpressure with i_valid held; the next pair waits for IDLE.
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 16'd144, 1, 1);
      bus.i_activation = 32'hAAAA_AAAA;
      bus.i_weight     = 32'h5555_5555;
      bus.i_A_signed   = 1'b1;
      bus.i_W_signed   = 1'b1;
      exp_q.push_back(16'hFFE0);
      collect(3, 5, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1 bus.i_valid = 1'b0;
      collect(3, 0, 1'b0, 1'b1, 1'b1);

      // Reset during pass 2 of a 4b operation.
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 16'd0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("pass2_act", bus.o_pe_activation, 32'h0000_FFFF);
      rst = 1'b1;
      #1;
      check("midrst_ready", 32'(bus.o_ready), 32'd1);
      check("midrst_valid", 32'(bus.o_valid), 32'd0);
      check("midrst_result", 32'($unsigned(bus.o_result)), 32'd0);
      check("midrst_pe", bus.o_pe_activation | bus.o_pe_weight, 32'd0);
      check("midrst_flags", 32'({bus.o_pe_A_signed, bus.o_pe_W_signed}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 16'd144, 1, 0);
      collect(3, 0, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
